nn_wb: RTL and testbench
========================

# nn_wb

Result write-back stage placed directly downstream of the PE array in `nn`. It consumes the paired per-cycle partial/final results (`o_result0`, `o_result1`) and applies an optional stream max-pool, optional ReLU, arithmetic right shift and signed 8-bit saturation. It packs the two lanes into one 16-bit word and drives the DMA write port (`o_dma_wr_addr/en/data`) at consecutive addresses from a configured base. A small output FIFO decouples PE output from DMA write back-pressure.

## Interface
- `DATA_WIDTH`, 8, quantized output byte width
- `OUT_WIDTH`, 16, signed PE result width per lane
- `DMA_ADDR_WIDTH`, 5, DMA word address width
- `FIFO_DEPTH`, 4, output word FIFO entries (power of two)

Ports:
- `i_clk` in 1: single clock, all state on rising edge
- `i_rst` in 1: synchronous, active-high reset
- `i_start` in 1: one-cycle pulse; latch config, clear counters/FIFO/pool state, enter RUN
- `i_base_addr` in DMA_ADDR_WIDTH: first write address, sampled on `i_start`
- `i_wr_count` in 16: words to write this run, sampled on `i_start`
- `i_pool` in 2: stream pool window minus 1 (0: none … 3: max of 4), sampled on `i_start`
- `i_relu` in 1: clamp negatives to 0, sampled on `i_start`
- `i_out_shift` in 4: arithmetic right shift before saturation, sampled on `i_start`
- `i_valid` in 1: result pair valid this cycle
- `i_result0`, `i_result1` in OUT_WIDTH: signed lane results
- `o_ready` out 1: stage can accept a pair this cycle
- `i_dma_wr_ready` in 1: DMA accepts a write this cycle
- `o_dma_wr_en` out 1, `o_dma_wr_addr` out DMA_ADDR_WIDTH, `o_dma_wr_data` out 16: DMA write
- `o_busy` out 1: state ≠ IDLE; `o_done` out 1: one-cycle pulse at run end

## Operation
- FSM: IDLE → (`i_start`) RUN → (last word written) DONE → IDLE. DONE lasts one cycle with `o_done`=1. `i_start` in any state restarts: FIFO, S1, pool and counters flushed, config re-sampled. `i_wr_count`=0 goes RUN→DONE on the next cycle with no writes.
- A pair is accepted when `i_valid & o_ready` in RUN. Pairs arriving in IDLE/DONE, or after `i_wr_count` words have been produced, are dropped.
- Pool: per lane, a signed running max over `i_pool`+1 accepted pairs. The window-completing pair emits one word; the window counter then resets. A partial window at restart or reset is discarded.
- Per lane, after pool: ReLU if enabled (negative → 0). Then `>>>` by `i_out_shift`, then saturate to [-128, 127].
- Packing: `o_dma_wr_data` = {lane1 byte, lane0 byte}.
- Address: base + written word index, modulo 2^DMA_ADDR_WIDTH (wraps 31→0).
- Write: `o_dma_wr_en` = FIFO non-empty & `i_dma_wr_ready`. Addr/data come from the FIFO head; a pop occurs in the same cycle.
- `o_ready` = RUN & (FIFO count + S1 pending word) ≤ FIFO_DEPTH−2. The FIFO never overflows.

## Timing
- S1 register: pool max + emit flag, written at the edge ending the accepting cycle t. The FIFO push happens at edge t+1. Earliest `o_dma_wr_en` is cycle t+2.
- Throughput: one word per cycle with `i_pool`=0 and ready held high.
- DONE is entered the cycle after the `i_wr_count`-th write.
- Reset values: `o_dma_wr_en`=0, `o_dma_wr_addr`=0, `o_dma_wr_data`=0, `o_ready`=0, `o_busy`=0, `o_done`=0. FIFO is empty, state is IDLE. Reset mid-run aborts with no `o_done`.
- A simultaneous FIFO push and pop keeps the count unchanged.

## Structure
- Shared package `nn_pkg`: state enum (IDLE/RUN/DONE) and saturation limits `SAT_MAX`=127, `SAT_MIN`=-128.
- One sub-module, `nn_wb_fifo` (synchronous FIFO, depth FIFO_DEPTH, 16+DMA_ADDR_WIDTH bits wide, count output). The pool/quant datapath and FSM stay in `nn_wb`.

## Test plan
- Basic: base=3, count=1, pool=0, relu=0, shift=0, pair (0x0005, 0xFFFD) → single write addr 3, data 0xFD05, exactly 2 cycles after `i_valid`; `o_done` next cycle.
- Shift/saturate: shift=4, (0x0123, 0x8000) → 0x8012. Shift=0, (0x0400, 0xFF00) → 0x807F. Same with relu=1 → 0x007F.
- Pool: pool=1, lane0 sequence 3, 9, -2, -7 with lane1 = 0 → two words: 0x0009, 0x00FE.
- Wrap: base=30, count=4 → addresses 30, 31, 0, 1. Extra pairs after the fourth are dropped and no fifth write occurs.
- Back-pressure: `i_dma_wr_ready`=0 for 10 cycles while 8 pairs are offered → `o_ready` falls once count+S1 > 2. No loss, 8 in-order writes after ready returns.
- Reset/restart: `i_rst` mid-run → all outputs 0 next cycle, no `o_done`. `i_start` with pending FIFO data → old words never written.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and helpers for the nn result write-back stage.
package nn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wb_state_e;

    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    function automatic logic [7:0] sat_s8(input logic signed [31:0] v);
        logic [7:0] r;
        if (v > SAT_MAX) begin
            r = 8'h7F;
        end else if (v < SAT_MIN) begin
            r = 8'h80;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/nn_wb_fifo.sv
// Synchronous word FIFO with flush and occupancy count; never pushed when full.
module nn_wb_fifo
    import nn_pkg::*;
#(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [PW:0]      cnt_q, cnt_d;

    // Pointer and count update; flush wins over any push/pop.
    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (i_flush) begin
            wp_d  = {PW{1'b0}};
            rp_d  = {PW{1'b0}};
            cnt_d = {(PW+1){1'b0}};
        end else begin
            if (i_push) begin
                wp_d = wp_q + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                wp_d = wp_q;
            end
            if (i_pop) begin
                rp_d = rp_q + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                rp_d = rp_q;
            end
            cnt_d = cnt_q + {{PW{1'b0}}, i_push} - {{PW{1'b0}}, i_pop};
        end
    end

    // Pointer/count registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wp_q  <= {PW{1'b0}};
            rp_q  <= {PW{1'b0}};
            cnt_q <= {(PW+1){1'b0}};
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) begin
            mem_q[wp_q] <= i_data;
        end
    end

    assign o_data  = mem_q[rp_q];
    assign o_empty = (cnt_q == {(PW+1){1'b0}});
    assign o_count = cnt_q;

endmodule

// File: rtl/nn_wb.sv
// Write-back stage: stream max-pool, ReLU, shift, saturate, pack two lanes and
// write them to DMA through a small decoupling FIFO.
module nn_wb
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int OUT_WIDTH      = 16,
    parameter int DMA_ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [DMA_ADDR_WIDTH-1:0] i_base_addr,
    input  logic [15:0]               i_wr_count,
    input  logic [1:0]                i_pool,
    input  logic                      i_relu,
    input  logic [3:0]                i_out_shift,
    input  logic                      i_valid,
    input  logic [OUT_WIDTH-1:0]      i_result0,
    input  logic [OUT_WIDTH-1:0]      i_result1,
    output logic                      o_ready,
    input  logic                      i_dma_wr_ready,
    output logic                      o_dma_wr_en,
    output logic [DMA_ADDR_WIDTH-1:0] o_dma_wr_addr,
    output logic [2*DATA_WIDTH-1:0]   o_dma_wr_data,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int AW = DMA_ADDR_WIDTH;
    localparam int WW = 2 * DATA_WIDTH;
    localparam int FW = WW + AW;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] OCC_MAX = (CW+1)'(FIFO_DEPTH - 2);

    function automatic logic [DATA_WIDTH-1:0] quant(input logic signed [OUT_WIDTH-1:0] v,
                                                    input logic relu,
                                                    input logic [3:0] sh);
        logic signed [OUT_WIDTH-1:0] t;
        if (relu && v[OUT_WIDTH-1]) begin
            t = {OUT_WIDTH{1'b0}};
        end else begin
            t = v;
        end
        t = t >>> sh;
        return DATA_WIDTH'(sat_s8(32'(t)));
    endfunction

    wb_state_e                   state_q, state_d;
    logic [AW-1:0]               base_q, base_d;
    logic [15:0]                 cnt_q, cnt_d;
    logic [1:0]                  pool_q, pool_d;
    logic                        relu_q, relu_d;
    logic [3:0]                  shift_q, shift_d;
    logic [1:0]                  win_q, win_d;
    logic signed [OUT_WIDTH-1:0] max0_q, max0_d, max1_q, max1_d;
    logic                        emit_q, emit_d;
    logic [15:0]                 prod_q, prod_d;
    logic [AW-1:0]               pidx_q, pidx_d;
    logic [15:0]                 wcnt_q, wcnt_d;
    logic                        busy_q, busy_d, done_q, done_d;

    logic                        fifo_empty_s, push_s, wr_en_s, ready_s, acc_s, last_s;
    logic [CW-1:0]               fifo_cnt_s;
    logic [CW:0]                 occ_s;
    logic [FW-1:0]               fifo_wdata_s, fifo_rdata_s;
    logic signed [OUT_WIDTH-1:0] in0_s, in1_s, cur0_s, cur1_s;

    assign in0_s   = $signed(i_result0);
    assign in1_s   = $signed(i_result1);
    assign occ_s   = {1'b0, fifo_cnt_s} + {{CW{1'b0}}, emit_q};
    assign ready_s = (state_q == ST_RUN) && (occ_s <= OCC_MAX);
    assign acc_s   = i_valid && ready_s && !i_start && (prod_q < cnt_q);
    // An old word must not leak out in the cycle that restarts the run.
    assign wr_en_s = !fifo_empty_s && i_dma_wr_ready && !i_start;
    assign push_s  = emit_q && !i_start;
    assign last_s  = (win_q == pool_q);
    assign cur0_s  = (win_q == 2'd0 || in0_s > max0_q) ? in0_s : max0_q;
    assign cur1_s  = (win_q == 2'd0 || in1_s > max1_q) ? in1_s : max1_q;
    assign fifo_wdata_s = {quant(max1_q, relu_q, shift_q), quant(max0_q, relu_q, shift_q),
                           base_q + pidx_q};

    // Next-state: config latch, pooling window, word counters and run FSM.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        pool_d  = pool_q;
        relu_d  = relu_q;
        shift_d = shift_q;
        win_d   = win_q;
        max0_d  = max0_q;
        max1_d  = max1_q;
        emit_d  = 1'b0;
        prod_d  = prod_q;
        pidx_d  = pidx_q;
        wcnt_d  = wcnt_q;
        if (i_start) begin
            state_d = ST_RUN;
            base_d  = i_base_addr;
            cnt_d   = i_wr_count;
            pool_d  = i_pool;
            relu_d  = i_relu;
            shift_d = i_out_shift;
            win_d   = 2'd0;
            prod_d  = 16'd0;
            pidx_d  = {AW{1'b0}};
            wcnt_d  = 16'd0;
        end else begin
            if (acc_s) begin
                max0_d = cur0_s;
                max1_d = cur1_s;
                emit_d = last_s;
                win_d  = last_s ? 2'd0 : win_q + 2'd1;
                prod_d = last_s ? prod_q + 16'd1 : prod_q;
            end else begin
                emit_d = 1'b0;
            end
            if (push_s) begin
                pidx_d = pidx_q + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                pidx_d = pidx_q;
            end
            if (wr_en_s) begin
                wcnt_d = wcnt_q + 16'd1;
            end else begin
                wcnt_d = wcnt_q;
            end
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_RUN: begin
                    if ((wcnt_q == cnt_q) || (wr_en_s && (wcnt_q + 16'd1 == cnt_q))) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            base_q  <= {AW{1'b0}};
            cnt_q   <= 16'd0;
            pool_q  <= 2'd0;
            relu_q  <= 1'b0;
            shift_q <= 4'd0;
            win_q   <= 2'd0;
            max0_q  <= {OUT_WIDTH{1'b0}};
            max1_q  <= {OUT_WIDTH{1'b0}};
            emit_q  <= 1'b0;
            prod_q  <= 16'd0;
            pidx_q  <= {AW{1'b0}};
            wcnt_q  <= 16'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            pool_q  <= pool_d;
            relu_q  <= relu_d;
            shift_q <= shift_d;
            win_q   <= win_d;
            max0_q  <= max0_d;
            max1_q  <= max1_d;
            emit_q  <= emit_d;
            prod_q  <= prod_d;
            pidx_q  <= pidx_d;
            wcnt_q  <= wcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    nn_wb_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_start),
        .i_push  (push_s),
        .i_data  (fifo_wdata_s),
        .i_pop   (wr_en_s),
        .o_data  (fifo_rdata_s),
        .o_empty (fifo_empty_s),
        .o_count (fifo_cnt_s)
    );

    assign o_ready       = ready_s;
    assign o_dma_wr_en   = wr_en_s;
    assign o_dma_wr_addr = fifo_empty_s ? {AW{1'b0}} : fifo_rdata_s[AW-1:0];
    assign o_dma_wr_data = fifo_empty_s ? {WW{1'b0}} : fifo_rdata_s[FW-1:AW];
    assign o_busy        = busy_q;
    assign o_done        = done_q;

endmodule

// File: tb/tb_nn_wb.sv
// Directed self-checking bench for nn_wb: latency, quantization, pooling,
// address wrap, back-pressure, reset and restart.
module tb_nn_wb;

    logic        i_clk = 1'b0;
    logic        i_rst, i_start, i_relu, i_valid, i_dma_wr_ready;
    logic [4:0]  i_base_addr;
    logic [15:0] i_wr_count, i_result0, i_result1;
    logic [1:0]  i_pool;
    logic [3:0]  i_out_shift;
    logic        o_ready, o_dma_wr_en, o_busy, o_done;
    logic [4:0]  o_dma_wr_addr;
    logic [15:0] o_dma_wr_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ndone = 0;
    int c0, dc, sent, nd0;
    bit saw_low;

    logic [4:0]  qa[$];
    logic [15:0] qd[$];
    int          qc[$];

    nn_wb dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_base_addr    (i_base_addr),
        .i_wr_count     (i_wr_count),
        .i_pool         (i_pool),
        .i_relu         (i_relu),
        .i_out_shift    (i_out_shift),
        .i_valid        (i_valid),
        .i_result0      (i_result0),
        .i_result1      (i_result1),
        .o_ready        (o_ready),
        .i_dma_wr_ready (i_dma_wr_ready),
        .o_dma_wr_en    (o_dma_wr_en),
        .o_dma_wr_addr  (o_dma_wr_addr),
        .o_dma_wr_data  (o_dma_wr_data),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (o_dma_wr_en) begin
            qa.push_back(o_dma_wr_addr);
            qd.push_back(o_dma_wr_data);
            qc.push_back(cyc);
        end
        if (o_done) ndone++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_log();
        qa.delete();
        qd.delete();
        qc.delete();
    endtask

    task automatic start(input logic [4:0] b, input logic [15:0] n, input logic [1:0] p,
                         input logic r, input logic [3:0] s);
        i_base_addr = b;
        i_wr_count  = n;
        i_pool      = p;
        i_relu      = r;
        i_out_shift = s;
        i_start     = 1'b1;
        step();
        i_start     = 1'b0;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        i_valid   = 1'b1;
        i_result0 = a;
        i_result1 = b;
        step();
        i_valid   = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int dcy);
        bit seen;
        seen = 1'b0;
        dcy  = -1;
        for (int k = 0; k < 60 && !seen; k++) begin
            if (o_done) begin
                seen = 1'b1;
                dcy  = cyc;
            end else begin
                step();
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic chk_log(input string tag, input int k, input logic [4:0] ea, input logic [15:0] ed);
        if (k < qa.size()) begin
            chk($sformatf("%s_addr%0d", tag, k), 32'(qa[k]), 32'(ea));
            chk($sformatf("%s_data%0d", tag, k), 32'(qd[k]), 32'(ed));
        end else begin
            chk($sformatf("%s_missing%0d", tag, k), 32'(qa.size()), 32'(k + 1));
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_en"},    32'(o_dma_wr_en),   32'd0);
        chk({tag, "_addr"},  32'(o_dma_wr_addr), 32'd0);
        chk({tag, "_data"},  32'(o_dma_wr_data), 32'd0);
        chk({tag, "_ready"}, 32'(o_ready),       32'd0);
        chk({tag, "_busy"},  32'(o_busy),        32'd0);
        chk({tag, "_done"},  32'(o_done),        32'd0);
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_relu = 1'b0; i_valid = 1'b0; i_dma_wr_ready = 1'b1;
        i_base_addr = 5'd0; i_wr_count = 16'd0; i_pool = 2'd0; i_out_shift = 4'd0;
        i_result0 = 16'd0; i_result1 = 16'd0;
        step(); step();
        chk_idle_outputs("reset");
        i_rst = 1'b0;
        step();

        // Basic single write with latency
        clear_log();
        start(5'd3, 16'd1, 2'd0, 1'b0, 4'd0);
        c0 = cyc;
        send(16'h0005, 16'hFFFD);
        wait_done("basic_done", dc);
        chk("basic_count", 32'(qa.size()), 32'd1);
        chk_log("basic", 0, 5'd3, 16'hFD05);
        if (qc.size() > 0) chk("basic_latency", 32'(qc[0] - c0), 32'd2);
        chk("basic_done_latency", 32'(dc - c0), 32'd3);
        step();

        // Shift and saturation
        clear_log();
        start(5'd0, 16'd1, 2'd0, 1'b0, 4'd4);
        send(16'h0123, 16'h8000);
        wait_done("sh4_done", dc); step();
        chk_log("sh4", 0, 5'd0, 16'h8012);
        clear_log();
        start(5'd0, 16'd1, 2'd0, 1'b0, 4'd0);
        send(16'h0400, 16'hFF00);
        wait_done("sat_done", dc); step();
        chk_log("sat", 0, 5'd0, 16'h807F);
        clear_log();
        start(5'd0, 16'd1, 2'd0, 1'b1, 4'd0);
        send(16'h0400, 16'hFF00);
        wait_done("relu_done", dc); step();
        chk_log("relu", 0, 5'd0, 16'h007F);

        // Pool window of two
        clear_log();
        start(5'd5, 16'd2, 2'd1, 1'b0, 4'd0);
        send(16'd3, 16'd0);
        send(16'd9, 16'd0);
        send(16'hFFFE, 16'd0);
        send(16'hFFF9, 16'd0);
        wait_done("pool_done", dc); step();
        chk("pool_count", 32'(qa.size()), 32'd2);
        chk_log("pool", 0, 5'd5, 16'h0009);
        chk_log("pool", 1, 5'd6, 16'h00FE);

        // Address wrap and dropping surplus pairs
        clear_log();
        start(5'd30, 16'd4, 2'd0, 1'b0, 4'd0);
        for (int k = 0; k < 6; k++) send(16'(k + 1), 16'd0);
        wait_done("wrap_done", dc);
        for (int k = 0; k < 5; k++) step();
        chk("wrap_count", 32'(qa.size()), 32'd4);
        for (int k = 0; k < 4; k++) chk_log("wrap", k, 5'(30 + k), 16'(k + 1));

        // Back-pressure
        clear_log();
        i_dma_wr_ready = 1'b0;
        start(5'd0, 16'd8, 2'd0, 1'b0, 4'd0);
        sent = 0; saw_low = 1'b0;
        for (int k = 0; k < 10; k++) begin
            i_valid   = (sent < 8);
            i_result0 = 16'(sent + 1);
            i_result1 = 16'(sent + 16);
            if (i_valid && o_ready) sent++;
            if (!o_ready) saw_low = 1'b1;
            step();
        end
        i_valid = 1'b0;
        chk("bp_accepted_stalled", 32'(sent), 32'd3);
        chk("bp_ready_low", 32'(saw_low), 32'd1);
        chk("bp_no_write_stalled", 32'(qa.size()), 32'd0);
        i_dma_wr_ready = 1'b1;
        for (int k = 0; k < 100 && sent < 8; k++) begin
            i_valid   = 1'b1;
            i_result0 = 16'(sent + 1);
            i_result1 = 16'(sent + 16);
            if (o_ready) sent++;
            step();
        end
        i_valid = 1'b0;
        wait_done("bp_done", dc); step();
        chk("bp_count", 32'(qa.size()), 32'd8);
        for (int k = 0; k < 8; k++) chk_log("bp", k, 5'(k), 16'(((k + 16) << 8) | (k + 1)));

        // Reset mid-run
        clear_log();
        i_dma_wr_ready = 1'b0;
        start(5'd0, 16'd4, 2'd0, 1'b0, 4'd0);
        send(16'd1, 16'd2);
        send(16'd3, 16'd4);
        step();
        i_rst = 1'b1;
        step();
        chk_idle_outputs("midrst");
        i_rst = 1'b0;
        nd0 = ndone;
        i_dma_wr_ready = 1'b1;
        for (int k = 0; k < 10; k++) step();
        chk("midrst_no_write", 32'(qa.size()), 32'd0);
        chk("midrst_no_done", 32'(ndone - nd0), 32'd0);

        // Restart with stale FIFO contents
        clear_log();
        i_dma_wr_ready = 1'b0;
        start(5'd0, 16'd4, 2'd0, 1'b0, 4'd0);
        send(16'h0011, 16'd0);
        send(16'h0022, 16'd0);
        step(); step();
        i_dma_wr_ready = 1'b1;
        start(5'd10, 16'd1, 2'd0, 1'b0, 4'd0);
        send(16'h0033, 16'd0);
        wait_done("restart_done", dc);
        for (int k = 0; k < 3; k++) step();
        chk("restart_count", 32'(qa.size()), 32'd1);
        chk_log("restart", 0, 5'd10, 16'h0033);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
